// File: rtl/seg_scan_ctrl_if.sv
// Character-buffer write bus for seg_scan_ctrl: one digit write per strobe.
interface seg_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic       wr_dp;

  modport master (output wr_en, wr_addr, wr_data, wr_dp);
  modport slave  (input  wr_en, wr_addr, wr_data, wr_dp);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: buffered characters, per-digit blink,
// active-low digit selects and segments, frame pulse at each scan wrap.
module seg_scan_ctrl #(
  parameter int NUM_DIG      = 8,
  parameter int DIV          = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  seg_scan_ctrl_if.slave     wr,
  input  logic [NUM_DIG-1:0] blink_mask,
  output logic [NUM_DIG-1:0] DIG,
  output logic [7:0]         Y,
  output logic               frame_done
);

  localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int CW = $clog2(DIV);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [4:0] CODE_BLANK = 5'd16;

  typedef struct packed {
    logic       dp;
    logic [4:0] code;
  } entry_t;

  entry_t          char_buf [NUM_DIG];
  logic [CW-1:0]   div_cnt;
  logic [IW-1:0]   idx;
  logic [FW-1:0]   frame_cnt;
  logic            blink_phase;

  logic            tick;
  logic            wrap;
  logic            wr_hit;

  assign tick   = (div_cnt == CW'(DIV - 1));
  assign wrap   = tick && (idx == IW'(NUM_DIG - 1));
  assign wr_hit = wr.wr_en && ({1'b0, wr.wr_addr} < 4'(NUM_DIG));

  function automatic logic [6:0] seg_decode(input logic [4:0] code);
    case (code)
      5'd0:    seg_decode = 7'b0111111;
      5'd1:    seg_decode = 7'b0000110;
      5'd2:    seg_decode = 7'b1011011;
      5'd3:    seg_decode = 7'b1001111;
      5'd4:    seg_decode = 7'b1100110;
      5'd5:    seg_decode = 7'b1101101;
      5'd6:    seg_decode = 7'b1111101;
      5'd7:    seg_decode = 7'b0000111;
      5'd8:    seg_decode = 7'b1111111;
      5'd9:    seg_decode = 7'b1101111;
      5'd10:   seg_decode = 7'b1110111;
      5'd11:   seg_decode = 7'b1111100;
      5'd12:   seg_decode = 7'b0111001;
      5'd13:   seg_decode = 7'b1011110;
      5'd14:   seg_decode = 7'b1111001;
      5'd15:   seg_decode = 7'b1110001;
      5'd17:   seg_decode = 7'b1110011;
      5'd18:   seg_decode = 7'b1000000;
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

  // Scan timing: divider, digit index, frame counter and blink phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt     <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      frame_done <= wrap;
      if (tick) begin
        idx <= wrap ? '0 : idx + 1'b1;
      end
      if (wrap) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // NOTE: the buffer is tiny and must read as blank from reset, so it is
  // built from flops with an async reset rather than an inferred RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_DIG; i++) begin
        char_buf[i] <= '{dp: 1'b0, code: CODE_BLANK};
      end
    end else if (wr_hit) begin
      char_buf[wr.wr_addr[IW-1:0]] <= '{dp: wr.wr_dp, code: wr.wr_data};
    end
  end

  entry_t             cur;
  logic [NUM_DIG-1:0] dig_next;
  logic [7:0]         y_next;

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    cur      = char_buf[idx];
    dig_next = '1;
    y_next   = 8'hFF;
    if (enable) begin
      dig_next = ~(NUM_DIG'(1) << idx);
      if (!(blink_mask[idx] && blink_phase)) begin
        y_next = {~cur.dp, ~seg_decode(cur.code)};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DIG <= '1;
      Y   <= 8'hFF;
    end else begin
      DIG <= dig_next;
      Y   <= y_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NUM_DIG=4, DIV=4, BLINK_FRAMES=2).
module tb_seg_scan_ctrl;

  localparam int N   = 4;
  localparam int DV  = 4;
  localparam int BF  = 2;
  localparam int FRM = N * DV;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [N-1:0] blink_mask;
  logic [N-1:0] DIG;
  logic [7:0]   Y;
  logic         frame_done;

  seg_scan_ctrl_if wr_bus ();

  seg_scan_ctrl #(.NUM_DIG(N), .DIV(DV), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr         (wr_bus.slave),
    .blink_mask (blink_mask),
    .DIG        (DIG),
    .Y          (Y),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: position in the scan derived from edges since reset.
  logic [6:0]   seg_tab [32];
  logic [4:0]   m_code  [N];
  logic         m_dp    [N];
  int           t;
  int           m_idx;
  int           m_phase;
  logic [N-1:0] exp_dig;
  logic [7:0]   exp_y;
  logic         exp_fd;

  initial begin
    for (int i = 0; i < 32; i++) seg_tab[i] = 7'b0000000;
    seg_tab[0]  = 7'b0111111; seg_tab[1]  = 7'b0000110;
    seg_tab[2]  = 7'b1011011; seg_tab[3]  = 7'b1001111;
    seg_tab[4]  = 7'b1100110; seg_tab[5]  = 7'b1101101;
    seg_tab[6]  = 7'b1111101; seg_tab[7]  = 7'b0000111;
    seg_tab[8]  = 7'b1111111; seg_tab[9]  = 7'b1101111;
    seg_tab[10] = 7'b1110111; seg_tab[11] = 7'b1111100;
    seg_tab[12] = 7'b0111001; seg_tab[13] = 7'b1011110;
    seg_tab[14] = 7'b1111001; seg_tab[15] = 7'b1110001;
    seg_tab[17] = 7'b1110011; seg_tab[18] = 7'b1000000;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t       = 0;
      exp_dig = '1;
      exp_y   = 8'hFF;
      exp_fd  = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_code[i] = 5'd16;
        m_dp[i]   = 1'b0;
      end
    end else begin
      m_idx   = (t / DV) % N;
      m_phase = ((t / FRM) / BF) % 2;
      if (!enable) begin
        exp_dig = '1;
        exp_y   = 8'hFF;
      end else begin
        exp_dig = '1;
        exp_dig[m_idx] = 1'b0;
        if (blink_mask[m_idx] && m_phase == 1) exp_y = 8'hFF;
        else exp_y = {~m_dp[m_idx], ~seg_tab[m_code[m_idx]]};
      end
      t      = t + 1;
      exp_fd = (t % FRM) == 0;
      if (wr_bus.wr_en && wr_bus.wr_addr < N) begin
        m_code[wr_bus.wr_addr] = wr_bus.wr_data;
        m_dp[wr_bus.wr_addr]   = wr_bus.wr_dp;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on && rst) begin
      check("model_dig", DIG, exp_dig);
      check("model_y", Y, exp_y);
      check("model_frame_done", frame_done, exp_fd);
    end
  end

  task automatic do_write(input logic [2:0] a, input logic [4:0] d, input logic dp);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_addr = a;
    wr_bus.wr_data = d;
    wr_bus.wr_dp   = dp;
    @(negedge clk);
    wr_bus.wr_en   = 1'b0;
  endtask

  task automatic wait_dig(input logic [N-1:0] target, input string name);
    int n = 0;
    while (DIG !== target && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, DIG, target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c_blank, c_show, c_d0, c_off, c_fd;
    rst = 1'b1; enable = 1'b1; blink_mask = '0;
    wr_bus.wr_en = 1'b0; wr_bus.wr_addr = '0; wr_bus.wr_data = '0; wr_bus.wr_dp = 1'b0;
    #1 rst = 1'b0;
    #20;
    check("reset_dig", DIG, 4'hF);
    check("reset_y", Y, 8'hFF);
    check("reset_frame_done", frame_done, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    cmp_on = 1'b1;
    wait_dig(4'hE, "blank_dig0"); check("blank_y0", Y, 8'hFF);
    wait_dig(4'hD, "blank_dig1"); check("blank_y1", Y, 8'hFF);
    wait_dig(4'hB, "blank_dig2"); check("blank_y2", Y, 8'hFF);
    wait_dig(4'h7, "blank_dig3"); check("blank_y3", Y, 8'hFF);

    // Fill the buffer: 1, 2 with dp, P, '-'.
    do_write(3'd0, 5'd1, 1'b0);
    do_write(3'd1, 5'd2, 1'b1);
    do_write(3'd2, 5'd17, 1'b0);
    do_write(3'd3, 5'd18, 1'b0);
    repeat (FRM) @(negedge clk);
    wait_dig(4'hE, "scan_dig0"); check("scan_y0", Y, 8'hF9);
    wait_dig(4'hD, "scan_dig1"); check("scan_y1", Y, 8'h24);
    wait_dig(4'hB, "scan_dig2"); check("scan_y2", Y, 8'h8C);
    wait_dig(4'h7, "scan_dig3"); check("scan_y3", Y, 8'hBF);

    n = 0;
    while (!frame_done && n < 40) begin @(negedge clk); n++; end
    check("frame_done_seen", frame_done, 1'b1);
    @(negedge clk);
    n = 1;
    while (!frame_done && n < 40) begin @(negedge clk); n++; end
    check("frame_done_period", n, FRM);

    // Out-of-range address aliases digit 1 in its low bits; must be dropped.
    do_write(3'd5, 5'd8, 1'b0);
    repeat (20) @(negedge clk);
    wait_dig(4'hD, "oob_dig1"); check("oob_write_ignored", Y, 8'h24);

    // Write the digit being shown, right after it became selected.
    n = 0;
    while (DIG === 4'hB && n < 40) begin @(negedge clk); n++; end
    while (DIG !== 4'hB && n < 80) begin @(negedge clk); n++; end
    check("sel_dig2", DIG, 4'hB);
    do_write(3'd2, 5'd0, 1'b1);
    check("sel_write_not_yet", Y, 8'h8C);
    @(negedge clk);
    check("sel_write_visible", Y, 8'h40);

    // Blink on digit 1: over one 64-cycle blink period half its slots are dark.
    blink_mask = 4'b0010;
    @(negedge clk);
    c_blank = 0; c_show = 0; c_d0 = 0;
    for (int i = 0; i < 4 * FRM; i++) begin
      @(negedge clk);
      if (DIG === 4'hD && Y === 8'hFF) c_blank++;
      if (DIG === 4'hD && Y === 8'h24) c_show++;
      if (DIG === 4'hE && Y === 8'hF9) c_d0++;
    end
    check("blink_dark_slots", c_blank, 8);
    check("blink_lit_slots", c_show, 8);
    check("blink_other_digit", c_d0, 16);
    blink_mask = '0;

    // Display off: blanked but still scanning and pulsing frame_done.
    enable = 1'b0;
    @(negedge clk);
    c_off = 0; c_fd = 0;
    for (int i = 0; i < 2 * FRM; i++) begin
      @(negedge clk);
      if (DIG === 4'hF && Y === 8'hFF) c_off++;
      if (frame_done === 1'b1) c_fd++;
    end
    check("disabled_blank_cycles", c_off, 2 * FRM);
    check("disabled_frame_pulses", c_fd, 2);
    enable = 1'b1;
    @(negedge clk);
    check("resume_dig_active", (DIG !== 4'hF), 1'b1);
    wait_dig(4'hE, "resume_dig0"); check("resume_y0", Y, 8'hF9);

    // Asynchronous reset between clock edges, mid-frame.
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset_dig", DIG, 4'hF);
    check("async_reset_y", Y, 8'hFF);
    check("async_reset_frame_done", frame_done, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_dig0", DIG, 4'hE);
    check("post_reset_y0", Y, 8'hFF);
    wait_dig(4'hD, "post_reset_dig1"); check("post_reset_y1", Y, 8'hFF);
    repeat (FRM) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIG, default 8: number of scanned digits, legal range 2..8.
REQ-002 SHALL have parameter DIV, default 100000: clk cycles per scan step, legal range 2 or more.
REQ-003 SHALL have parameter BLINK_FRAMES, default 64: full scan frames per blink half-period, legal range 1 or more.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1 bit: display on; when 0, all digits are blanked and scanning continues.
REQ-007 SHALL have port wr_en, input, 1 bit: write strobe for the character buffer.
REQ-008 SHALL have port wr_addr, input, 3 bits: digit index to write.
REQ-009 SHALL have port wr_data, input, 5 bits: character code to write.
REQ-010 SHALL have port wr_dp, input, 1 bit: decimal point for the written digit.
REQ-011 SHALL have port blink_mask, input, NUM_DIG bits: per-digit blink enable.
REQ-012 SHALL have port DIG, output, NUM_DIG bits: digit selects, active-low.
REQ-013 SHALL have port Y, output, 8 bits: segments, active-low; Y[7] is dp, Y[6:0] is g..a.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each scan frame.

Function
REQ-015 SHALL keep a buffer of NUM_DIG entries, each 6 bits (dp plus code); a write with wr_en=1 updates buffer[wr_addr] at the clk edge.
REQ-016 SHALL ignore any write with wr_addr >= NUM_DIG; no entry changes.
REQ-017 SHALL run a divider counting 0..DIV-1; tick is asserted for one cycle when the count equals DIV-1, and the count then wraps to 0.
REQ-018 SHALL advance the scan index on each tick, 0..NUM_DIG-1, wrapping from NUM_DIG-1 to 0.
REQ-019 SHALL pulse frame_done high for exactly the one cycle in which the index wraps from NUM_DIG-1 to 0.
REQ-020 SHALL count completed frames 0..BLINK_FRAMES-1 and toggle blink_phase when that count wraps.
REQ-021 SHALL register DIG and Y, computed from the current index and buffer; a buffer write at edge k is visible on Y at edge k+1 if that digit is selected.
REQ-022 SHALL drive DIG low only at bit [index]; all other bits stay high.
REQ-023 SHALL map codes to Y[6:0] before inversion, written gfedcba:
- 0 = 0111111
- 1 = 0000110
- 2 = 1011011
- 3 = 1001111
- 4 = 1100110
- 5 = 1101101
- 6 = 1111101
- 7 = 0000111
- 8 = 1111111
- 9 = 1101111
- A = 1110111
- b = 1111100
- C = 0111001
- d = 1011110
- E = 1111001
- F = 1110001
- 16 = blank (0000000)
- 17 = P (1110011)
- 18 = '-' (1000000)
- 19..31 = blank (0000000)
REQ-024 SHALL set Y[7] = ~dp.
REQ-025 SHALL force DIG all ones and Y = 8'hFF when enable=0.
REQ-026 SHALL force Y = 8'hFF, with DIG still scanning, when blink_mask[index]=1 and blink_phase=1.
REQ-027 SHALL apply wr_en simultaneous with a tick normally: the write and the index advance both take effect at the same edge.
REQ-028 SHALL take effect on blink_mask and enable changes at the next clk edge.

Reset
REQ-029 SHALL, while rst=0 and regardless of clk: DIG = all ones, Y = 8'hFF, frame_done=0, divider=0, index=0, frame count=0, blink_phase=0, all buffer entries = code 16 with dp=0.
REQ-030 SHALL, on rst deassertion mid-frame, restart scanning at index 0; the first tick occurs DIV cycles after the first clk edge with rst=1.

Verification
Test configuration: NUM_DIG=4, DIV=4, BLINK_FRAMES=2.
REQ-031 SHALL check reset: rst=0 asserted asynchronously mid-cycle -> DIG=4'hF and Y=8'hFF immediately; after release, a blank frame is shown with DIG stepping E,D,B,7.
REQ-032 SHALL check writes and scan: write addr0=1, addr1=2 with dp, addr2=17, addr3=18, enable=1 -> per step Y = F9, 24, 8C, BF with the matching DIG; frame_done pulses every 16 cycles.
REQ-033 SHALL check write edge cases: write to addr 5 -> buffer unchanged; write to the currently selected digit -> Y changes one cycle later.
REQ-034 SHALL check blink: blink_mask=4'b0010 -> digit1 Y=FF during alternate 2-frame windows and normal otherwise; other digits are unaffected.
REQ-035 SHALL check enable: enable=0 -> DIG=F and Y=FF while frame_done keeps pulsing; enable=1 -> display resumes at the current index.
